// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the multi-master system-bus arbiter.
package bus_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int unsigned MODE_FIXED = 0;
    localparam int unsigned MODE_RR    = 1;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) begin
            res++;
        end
        return res;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational masked picker: first requester at or after start_i, wrapping at N.
module arb_pick
    import bus_arb_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    input  logic [N-1:0]  mask_i,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            int unsigned j;
            // Explicit wrap so non-power-of-two N never indexes past N-1.
            j = 32'(start_i) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!valid_o && req_i[j[IW-1:0]] && mask_i[j[IW-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_master_arbiter.sv
// N-master, single-slave bus arbiter with fixed/round-robin policy, high-priority
// override mask, whole-transaction grant hold and slave-timeout abort.
module bus_master_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned          N_MASTERS  = 2,
    parameter int unsigned          ADDR_W     = 16,
    parameter int unsigned          DATA_W     = 8,
    parameter int unsigned          MODE       = MODE_FIXED,
    parameter logic [N_MASTERS-1:0] HIPRI_MASK = 'b1,
    parameter int unsigned          TIMEOUT    = 255
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [N_MASTERS-1:0]        i_m_cs,
    input  logic [N_MASTERS-1:0]        i_m_we,
    input  logic [N_MASTERS*ADDR_W-1:0] i_m_addr,
    input  logic [N_MASTERS*DATA_W-1:0] i_m_dat,
    output logic [N_MASTERS-1:0]        o_m_ack,
    output logic [N_MASTERS-1:0]        o_m_err,
    output logic [DATA_W-1:0]           o_m_dat,
    output logic [N_MASTERS-1:0]        o_grant,
    output logic [ADDR_W-1:0]           o_addr,
    output logic [DATA_W-1:0]           o_dat,
    output logic                        o_cs,
    output logic                        o_we,
    input  logic [DATA_W-1:0]           i_dat,
    input  logic                        i_ack
);

    localparam int unsigned IW        = clog2(N_MASTERS);
    localparam int unsigned CW        = (TIMEOUT == 0) ? 1 : clog2(TIMEOUT + 1);
    localparam bit          TmoEn     = (TIMEOUT != 0);
    localparam logic [CW-1:0] CntMax  = {CW{1'b1}};
    localparam logic [CW-1:0] CntTmo  = CW'(TIMEOUT);
    localparam logic [IW-1:0] LastIdx = IW'(N_MASTERS - 1);

    state_e                 state_q, state_d;
    logic [N_MASTERS-1:0]   grant_q, grant_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;

    logic [IW-1:0]          hp_idx, rot_idx, win_idx;
    logic                   hp_valid, rot_valid;
    logic [IW-1:0]          rot_start;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_dat;
    logic                   sel_we, sel_cs;
    logic                   busy, ack_hit, tmo_hit;

    assign rot_start = (MODE == MODE_RR) ? rr_ptr_q : '0;

    arb_pick #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_pick_hipri (
        .req_i   (i_m_cs),
        .start_i ('0),
        .mask_i  (HIPRI_MASK),
        .idx_o   (hp_idx),
        .valid_o (hp_valid)
    );

    arb_pick #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_pick_rot (
        .req_i   (i_m_cs),
        .start_i (rot_start),
        .mask_i  ({N_MASTERS{1'b1}}),
        .idx_o   (rot_idx),
        .valid_o (rot_valid)
    );

    assign win_idx = hp_valid ? hp_idx : rot_idx;

    // grant_q is all-zero in IDLE, so the bus mux yields zeros there.
    always_comb begin
        sel_addr = '0;
        sel_dat  = '0;
        sel_we   = 1'b0;
        sel_cs   = 1'b0;
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
            if (grant_q[k]) begin
                sel_addr = i_m_addr[k*ADDR_W +: ADDR_W];
                sel_dat  = i_m_dat[k*DATA_W +: DATA_W];
                sel_we   = i_m_we[k];
                sel_cs   = i_m_cs[k];
            end
        end
    end

    assign busy    = (state_q == ST_BUSY);
    assign ack_hit = busy && sel_cs && i_ack;
    // Ack outranks a same-cycle timeout.
    assign tmo_hit = TmoEn && busy && sel_cs && !i_ack && (cnt_q == CntTmo);

    assign o_grant = grant_q;
    assign o_addr  = sel_addr;
    assign o_dat   = sel_dat;
    assign o_we    = sel_we;
    assign o_cs    = sel_cs && !tmo_hit;
    assign o_m_ack = ack_hit ? grant_q : '0;
    assign o_m_err = tmo_hit ? grant_q : '0;
    assign o_m_dat = i_dat;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (rot_valid) begin
                    state_d          = ST_BUSY;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    cnt_d            = '0;
                    rr_ptr_d         = (win_idx == LastIdx) ? '0 : win_idx + 1'b1;
                end
            end
            ST_BUSY: begin
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // A dropped request aborts silently; any slave ack that cycle is ignored.
                if (ack_hit || !sel_cs || tmo_hit) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule
